// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : contador_pkg
// Purpose  : Shared types and constants for the sensor direction decoder that
//            drives the 7-bit up/down counter.
// Contents : estado_t   - decoder FSM states
//            DEFAULT_WIDTH - counter width
//            UP / DOWN  - values of the up_down direction level
// Revision : 1.0 - initial release
// ============================================================================
package contador_pkg;

  localparam int DEFAULT_WIDTH = 7;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // A* states track an outer-to-inner pass, B* the mirror pass.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A1   = 3'd1,
    A2   = 3'd2,
    A3   = 3'd3,
    B1   = 3'd4,
    B2   = 3'd5,
    B3   = 3'd6,
    ERR  = 3'd7
  } estado_t;

endpackage : contador_pkg
`default_nettype wire

// File: rtl/modulo_sincronizador_sensor.sv
`default_nettype none
// ============================================================================
// Module   : modulo_sincronizador_sensor
// Purpose  : Brings one asynchronous beam sensor into the clk domain through a
//            2-FF synchroniser and, when SENSOR_DEBOUNCE_EN is defined, a
//            debounce filter that only follows the input after it has been
//            stable for DEBOUNCE_CYCLES consecutive samples.
// Ports    : clk      - clock
//            clr      - synchronous active-high reset
//            sens_in  - raw asynchronous sensor (1 = beam blocked)
//            sens_out - synchronised (and optionally filtered) sensor
// Macro    : SENSOR_DEBOUNCE_EN - compiles in the debounce filter
// Revision : 1.0 - initial release
// ============================================================================
module modulo_sincronizador_sensor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic sens_in,
  output logic sens_out
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sens_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LAST_I = (DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt counts how many consecutive samples have disagreed with the current
  // filtered value; the filter flips on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sens_out = filt_q;
`else
  // Debounce length has no effect in this build.
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);

  assign sens_out = sync2_q;
`endif

endmodule : modulo_sincronizador_sensor
`default_nettype wire

// File: rtl/modulo_decodificador_sentido_sensores.sv
`default_nettype none
// ============================================================================
// Module   : modulo_decodificador_sentido_sensores
// Purpose  : Direction decoder for a two-beam doorway (A = outer, B = inner).
//            Recognises complete A->B passes (count up) and B->A passes
//            (count down) and issues a one-cycle enable strobe with a matching
//            up_down level to the counter. The counter value q is fed back so
//            no strobe is issued past 2^WIDTH-1 or below 0; such a pass gives
//            a one-cycle sat pulse instead.
// Ports    : clk     - clock
//            clr     - synchronous active-high reset
//            sens_a  - outer sensor, asynchronous, 1 = blocked
//            sens_b  - inner sensor, asynchronous, 1 = blocked
//            q       - current counter value
//            up_down - count direction (1 = up), held between strobes
//            enable  - one-cycle count strobe
//            sat     - one-cycle pulse for a pass suppressed at a bound
//            err     - high while both beams were seen blocked from idle
// Macro    : SENSOR_DEBOUNCE_EN - adds a debounce filter per sensor
// Revision : 1.0 - initial release
// ============================================================================
module modulo_decodificador_sentido_sensores
  import contador_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sens_a,
  input  logic             sens_b,
  input  logic [WIDTH-1:0] q,
  output logic             up_down,
  output logic             enable,
  output logic             sat,
  output logic             err
);

  localparam logic [WIDTH-1:0] Q_MAX = '1;
  localparam logic [WIDTH-1:0] Q_MIN = '0;

  logic a;
  logic b;

  modulo_sincronizador_sensor #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_a (
    .clk      (clk),
    .clr      (clr),
    .sens_in  (sens_a),
    .sens_out (a)
  );

  modulo_sincronizador_sensor #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_b (
    .clk      (clk),
    .clr      (clr),
    .sens_in  (sens_b),
    .sens_out (b)
  );

  estado_t state_q;
  estado_t state_d;
  logic    ev_up;
  logic    ev_down;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Unlisted sensor combinations hold the current state.
  always_comb begin
    state_d = state_q;
    ev_up   = 1'b0;
    ev_down = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a && !b)      state_d = A1;
        else if (!a && b) state_d = B1;
        else if (a && b)  state_d = ERR;
      end
      A1: begin
        if (a && b)        state_d = A2;
        else if (!a && !b) state_d = IDLE;
      end
      A2: begin
        if (!a && b)      state_d = A3;
        else if (a && !b) state_d = A1;
      end
      A3: begin
        if (!a && !b) begin
          state_d = IDLE;
          ev_up   = 1'b1;
        end else if (a && b) begin
          state_d = A2;
        end
      end
      B1: begin
        if (a && b)        state_d = B2;
        else if (!a && !b) state_d = IDLE;
      end
      B2: begin
        if (a && !b)      state_d = B3;
        else if (!a && b) state_d = B1;
      end
      B3: begin
        if (!a && !b) begin
          state_d = IDLE;
          ev_down = 1'b1;
        end else if (a && b) begin
          state_d = B2;
        end
      end
      ERR: begin
        if (!a && !b) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic up_down_q;
  logic up_down_d;
  logic enable_q;
  logic enable_d;
  logic sat_q;
  logic sat_d;

  // Bound check uses q in the cycle the event is decided; up_down and enable
  // are registered together so the direction is valid with the strobe.
  always_comb begin
    up_down_d = up_down_q;
    enable_d  = 1'b0;
    sat_d     = 1'b0;
    if (ev_up) begin
      if (q != Q_MAX) begin
        up_down_d = UP;
        enable_d  = 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end else if (ev_down) begin
      if (q != Q_MIN) begin
        up_down_d = DOWN;
        enable_d  = 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      up_down_q <= UP;
      enable_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      up_down_q <= up_down_d;
      enable_q  <= enable_d;
      sat_q     <= sat_d;
    end
  end

  assign up_down = up_down_q;
  assign enable  = enable_q;
  assign sat     = sat_q;
  assign err     = (state_q == ERR);

endmodule : modulo_decodificador_sentido_sensores
`default_nettype wire
